// File: rtl/diffeq_pkg.sv
// Shared definitions for the differential-equation sequencer.
// State codes are driven straight onto the datapath's `state` input, so the
// encodings below must match the datapath's decode.
// Operand indices give the order in which nibbles arrive on the `in` bus.
package diffeq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_READ = 3'b001,
        S_C1   = 3'b010,
        S_C2   = 3'b011,
        S_C3   = 3'b100,
        S_C4   = 3'b101,
        S_DONE = 3'b110
    } state_t;

    localparam logic [1:0] OP_X  = 2'd0;
    localparam logic [1:0] OP_DX = 2'd1;
    localparam logic [1:0] OP_A  = 2'd2;
    localparam logic [1:0] OP_U  = 2'd3;

endpackage

// File: rtl/cycle_watchdog.sv
// Per-state cycle watchdog for compute-unit controllers.
// Counts enabled cycles since the last clear. o_expired is high during the
// TIMEOUT-th enabled cycle after a clear, so a controller that leaves on
// o_expired spends exactly TIMEOUT cycles in the guarded state.
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset
//   i_clear    restart the count (asserted on the edge entering a state)
//   i_enable   count this cycle
//   o_expired  limit reached in the current cycle
module cycle_watchdog #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [TO_W-1:0] r_count;
    logic            w_hit;

    assign w_hit     = (r_count >= TO_W'(TIMEOUT - 1));
    assign o_expired = i_enable && w_hit;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_hit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/diffeq_sequencer.sv
// Control FSM for the differential-equation datapath.
// Streams the x, dx, a, u operand nibbles into the datapath, steps it through
// C1..C4 once per loop iteration, and ends the run on the loop-exit flag, the
// iteration cap or a per-state watchdog timeout.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start                 run request (IDLE only)
//   i_in_valid / o_in_ready operand nibble handshake on the datapath bus
//   i_compute_done          datapath completion for the current compute state
//   i_continue_while        datapath loop condition, looked at on C4 exit
//   o_state                 state code to the datapath
//   o_load_x/dx/a/u         operand capture strobes to the datapath
//   o_dp_reset              one-cycle datapath clear at the start of a run
//   o_busy, o_done          run in progress / one-cycle completion pulse
//   o_timeout_err           last run ended by watchdog
//   o_iter_count            completed iterations of the last or current run
//
// state  | meaning
// IDLE   | waiting for start
// READ   | first cycle clears datapath, then accepts x, dx, a, u in order
// C1..C4 | compute steps; cycle 0 is a settle cycle, compute_done advances
// DONE   | one-cycle completion pulse
module diffeq_sequencer
    import diffeq_pkg::*;
#(
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8,
    parameter int TIMEOUT  = 16,
    parameter int TO_W     = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_compute_done,
    input  logic              i_continue_while,
    output logic [2:0]        o_state,
    output logic              o_load_x,
    output logic              o_load_dx,
    output logic              o_load_a,
    output logic              o_load_u,
    output logic              o_dp_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout_err,
    output logic [ITER_W-1:0] o_iter_count
);

    state_t              r_state;
    state_t              w_next;
    logic                r_first;
    logic [1:0]          r_idx;
    logic [ITER_W-1:0]   r_iter;
    logic                r_to_err;

    logic                w_compute;
    logic                w_accept;
    logic                w_step;
    logic                w_expired;
    logic                w_timeout;
    logic                w_wd_clear;
    logic [ITER_W-1:0]   w_iter_inc;

    assign w_compute  = (r_state == S_C1) || (r_state == S_C2) ||
                        (r_state == S_C3) || (r_state == S_C4);
    assign w_accept   = (r_state == S_READ) && !r_first && i_in_valid;
    // compute_done is one clock stale on state entry, so ignore it there
    assign w_step     = w_compute && !r_first && i_compute_done;
    assign w_timeout  = w_compute && !w_step && w_expired;
    assign w_wd_clear = (w_next != r_state);
    assign w_iter_inc = (r_iter == ITER_W'(MAX_ITER)) ? r_iter : r_iter + 1'b1;

    cycle_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_compute),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_first  <= 1'b0;
            r_idx    <= '0;
            r_iter   <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
            if (r_state == S_IDLE && i_start) begin
                r_iter   <= '0;
                r_to_err <= 1'b0;
            end
            if (r_state == S_READ) begin
                if (r_first) begin
                    r_idx <= '0;
                end else if (w_accept) begin
                    r_idx <= r_idx + 2'd1;
                end
            end
            if (r_state == S_C4 && w_step) begin
                r_iter <= w_iter_inc;
            end
            if (w_timeout) begin
                r_to_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        o_load_x   = 1'b0;
        o_load_dx  = 1'b0;
        o_load_a   = 1'b0;
        o_load_u   = 1'b0;
        o_in_ready = 1'b0;
        o_dp_reset = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_READ;
            end
            S_READ: begin
                o_dp_reset = r_first;
                o_in_ready = !r_first;
                if (w_accept) begin
                    case (r_idx)
                        OP_X:    o_load_x  = 1'b1;
                        OP_DX:   o_load_dx = 1'b1;
                        OP_A:    o_load_a  = 1'b1;
                        OP_U:    o_load_u  = 1'b1;
                        default: o_load_x  = 1'b0;
                    endcase
                    if (r_idx == OP_U) w_next = S_C1;
                end
            end
            S_C1: begin
                if (w_step) w_next = S_C2;
                else if (w_expired) w_next = S_DONE;
            end
            S_C2: begin
                if (w_step) w_next = S_C3;
                else if (w_expired) w_next = S_DONE;
            end
            S_C3: begin
                if (w_step) w_next = S_C4;
                else if (w_expired) w_next = S_DONE;
            end
            S_C4: begin
                if (w_step) begin
                    if (i_continue_while && (w_iter_inc < ITER_W'(MAX_ITER)))
                        w_next = S_C1;
                    else
                        w_next = S_DONE;
                end else if (w_expired) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign o_state       = r_state;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_timeout_err = r_to_err;
    assign o_iter_count  = r_iter;

endmodule

// File: tb/tb_diffeq_sequencer.sv
// Two sequencers share one stimulus stream: A with default limits, B with
// MAX_ITER=3 / TIMEOUT=4. Each is compared every cycle against a phase/dwell
// reference model, plus a table for the basic run and targeted sequences.
module tb_diffeq_sequencer;

    localparam int A_MAX = 255, A_TO = 16, B_MAX = 3, B_TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, start_i, vld_i, cd_i, cw_i;

    logic       a_rdy, a_lx, a_ldx, a_la, a_lu, a_dpr, a_busy, a_done, a_to;
    logic [2:0] a_state;
    logic [7:0] a_iter;
    logic       b_rdy, b_lx, b_ldx, b_la, b_lu, b_dpr, b_busy, b_done, b_to;
    logic [2:0] b_state;
    logic [7:0] b_iter;

    diffeq_sequencer #(.MAX_ITER(A_MAX), .ITER_W(8), .TIMEOUT(A_TO), .TO_W(5)) dut_a (
        .i_clk(clk), .i_reset(rst_i), .i_start(start_i), .i_in_valid(vld_i),
        .o_in_ready(a_rdy), .i_compute_done(cd_i), .i_continue_while(cw_i),
        .o_state(a_state), .o_load_x(a_lx), .o_load_dx(a_ldx), .o_load_a(a_la),
        .o_load_u(a_lu), .o_dp_reset(a_dpr), .o_busy(a_busy), .o_done(a_done),
        .o_timeout_err(a_to), .o_iter_count(a_iter));

    diffeq_sequencer #(.MAX_ITER(B_MAX), .ITER_W(8), .TIMEOUT(B_TO), .TO_W(5)) dut_b (
        .i_clk(clk), .i_reset(rst_i), .i_start(start_i), .i_in_valid(vld_i),
        .o_in_ready(b_rdy), .i_compute_done(cd_i), .i_continue_while(cw_i),
        .o_state(b_state), .o_load_x(b_lx), .o_load_dx(b_ldx), .o_load_a(b_la),
        .o_load_u(b_lu), .o_dp_reset(b_dpr), .o_busy(b_busy), .o_done(b_done),
        .o_timeout_err(b_to), .o_iter_count(b_iter));

    logic [19:0] obs_a, obs_b, last_a, last_b;
    assign obs_a = {a_state, a_lx, a_ldx, a_la, a_lu, a_dpr, a_rdy, a_busy, a_done, a_to, a_iter};
    assign obs_b = {b_state, b_lx, b_ldx, b_la, b_lu, b_dpr, b_rdy, b_busy, b_done, b_to, b_iter};

    // phase: 0 idle, 1 read, 2..5 compute steps 1..4, 6 done
    // dwell: cycles already spent in the current phase
    typedef struct {
        int phase;
        int dwell;
        int idx;
        int iter;
        bit to_err;
    } mdl_t;

    mdl_t ma, mb;

    typedef struct {
        logic       st, v, d, w;
        logic [2:0] s;
        logic [3:0] ld;
        logic       dpr, rdy, dn;
        logic [7:0] it;
    } vec_t;

    vec_t tbl[$];

    int errors = 0, checks = 0, cyc = 0;
    int done_a, done_b, dpr_a, loads_a, ld_bad_a, comp_a, c2_b;

    function automatic logic [19:0] mdl_out(input mdl_t m, input logic v);
        logic [3:0] ld;
        logic       rd, dpr;
        rd  = (m.phase == 1) && (m.dwell > 0);
        dpr = (m.phase == 1) && (m.dwell == 0);
        ld  = 4'b0000;
        if (rd && v) ld = 4'b1000 >> m.idx;
        return {3'(m.phase), ld, dpr, rd, (m.phase != 0), (m.phase == 6), m.to_err, 8'(m.iter)};
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic r, s, v, d, w,
                                      input int mx, input int tmo);
        mdl_t n;
        int   np;
        n  = m;
        np = m.phase;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        case (m.phase)
            0: if (s) begin np = 1; n.iter = 0; n.to_err = 0; end
            1: begin
                if (m.dwell == 0) n.idx = 0;
                else if (v) begin
                    if (m.idx == 3) np = 2;
                    else n.idx = m.idx + 1;
                end
            end
            2, 3, 4, 5: begin
                if (m.dwell >= 1 && d) begin
                    if (m.phase == 5) begin
                        n.iter = (m.iter + 1 > mx) ? mx : m.iter + 1;
                        np = (w && n.iter < mx) ? 2 : 6;
                    end else begin
                        np = m.phase + 1;
                    end
                end else if (m.dwell + 1 >= tmo) begin
                    n.to_err = 1;
                    np = 6;
                end
            end
            default: np = 0;
        endcase
        n.dwell = (np != m.phase) ? 0 : m.dwell + 1;
        n.phase = np;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clr();
        done_a = 0; done_b = 0; dpr_a = 0; loads_a = 0; ld_bad_a = 0; comp_a = 0; c2_b = 0;
    endtask

    task automatic cycle(input logic r, s, v, d, w);
        rst_i = r; start_i = s; vld_i = v; cd_i = d; cw_i = w;
        #1;
        check("dut_a_outputs", 32'(obs_a), 32'(mdl_out(ma, v)));
        check("dut_b_outputs", 32'(obs_b), 32'(mdl_out(mb, v)));
        last_a = obs_a;
        last_b = obs_b;
        if (a_done) done_a++;
        if (b_done) done_b++;
        if (a_dpr) dpr_a++;
        if (a_lx | a_ldx | a_la | a_lu) begin
            loads_a++;
            if (!v) ld_bad_a++;
        end
        if (a_state inside {3'd2, 3'd3, 3'd4, 3'd5}) comp_a++;
        if (b_state == 3'd3) c2_b++;
        @(posedge clk);
        ma = mdl_step(ma, r, s, v, d, w, A_MAX, A_TO);
        mb = mdl_step(mb, r, s, v, d, w, B_MAX, B_TO);
        cyc++;
        @(negedge clk);
    endtask

    task automatic add(input logic st, v, d, w, input logic [2:0] s, input logic [3:0] ld,
                       input logic dpr, rdy, dn, input logic [7:0] it);
        vec_t t;
        t.st = st; t.v = v; t.d = d; t.w = w; t.s = s; t.ld = ld;
        t.dpr = dpr; t.rdy = rdy; t.dn = dn; t.it = it;
        tbl.push_back(t);
    endtask

    // mode 2 loop, 3 stalls, 4 C2 timeout, 5 done vs expiry tie, 6 cap, 7 start in READ
    task automatic run(input int mode, input int budget);
        int         n, rc;
        logic       s, v, d, w;
        logic [6:0] pat;
        pat = 7'b1001011;
        clr();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n = 0; rc = 0;
        while ((ma.phase != 0 || mb.phase != 0) && n < budget) begin
            s = 1'b0; v = 1'b1; d = 1'b1; w = 1'b0;
            case (mode)
                2: w = (ma.iter < 3);
                3: begin
                    v = 1'b0;
                    if (ma.phase == 1 && ma.dwell > 0) begin
                        v = pat[6 - (rc % 7)];
                        rc++;
                    end
                end
                4: d = (mb.phase != 3);
                5: d = (mb.phase != 3) || (mb.dwell == 3);
                6: w = (mb.phase != 0);
                7: if (ma.phase == 1 && ma.dwell == 1) begin s = 1'b1; v = 1'b0; end
                default: ;
            endcase
            cycle(1'b0, s, v, d, w);
            n++;
        end
        check("run_finished_in_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit at cycle %0d: got running, expected finished", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        rst_i = 1'b1; start_i = 1'b0; vld_i = 1'b0; cd_i = 1'b0; cw_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ma = '{default: 0};
        mb = '{default: 0};

        // basic single-iteration run, expected values written out per cycle
        //  st v  d  w  state   loads    dpr rdy done iter
        add(1, 0, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 8'd0);
        add(0, 1, 0, 0, 3'd1, 4'b0000, 1, 0, 0, 8'd0);
        add(0, 1, 0, 0, 3'd1, 4'b1000, 0, 1, 0, 8'd0);
        add(0, 1, 0, 0, 3'd1, 4'b0100, 0, 1, 0, 8'd0);
        add(0, 1, 0, 0, 3'd1, 4'b0010, 0, 1, 0, 8'd0);
        add(0, 1, 0, 0, 3'd1, 4'b0001, 0, 1, 0, 8'd0);
        add(0, 0, 0, 0, 3'd2, 4'b0000, 0, 0, 0, 8'd0);
        add(0, 0, 1, 0, 3'd2, 4'b0000, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 3'd3, 4'b0000, 0, 0, 0, 8'd0);
        add(0, 0, 1, 0, 3'd3, 4'b0000, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 3'd4, 4'b0000, 0, 0, 0, 8'd0);
        add(0, 0, 1, 0, 3'd4, 4'b0000, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 3'd5, 4'b0000, 0, 0, 0, 8'd0);
        add(0, 0, 1, 0, 3'd5, 4'b0000, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 3'd6, 4'b0000, 0, 0, 1, 8'd1);
        add(0, 0, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 8'd1);
        clr();
        foreach (tbl[i]) begin
            cycle(1'b0, tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].w);
            check("basic_run_row", 32'(last_a),
                  32'({tbl[i].s, tbl[i].ld, tbl[i].dpr, tbl[i].rdy, (tbl[i].s != 3'd0),
                       tbl[i].dn, 1'b0, tbl[i].it}));
        end
        check("basic_done_pulses", done_a, 1);

        run(2, 200);
        check("loop_iter_a", 32'(a_iter), 32'd4);
        check("loop_iter_b_capped", 32'(b_iter), 32'd3);
        check("loop_done_a", done_a, 1);
        check("loop_done_b", done_b, 1);

        run(3, 200);
        check("stall_load_count", loads_a, 4);
        check("stall_load_without_valid", ld_bad_a, 0);
        check("stall_compute_cycles", comp_a, 8);
        check("stall_done", done_a, 1);

        run(4, 200);
        check("wd_c2_dwell", c2_b, 4);
        check("wd_timeout_err_b", 32'(b_to), 32'd1);
        check("wd_iter_b", 32'(b_iter), 32'd0);
        check("wd_done_b", done_b, 1);
        check("wd_timeout_err_a", 32'(a_to), 32'd0);

        run(5, 200);
        check("tie_c2_dwell", c2_b, 4);
        check("tie_timeout_err_b", 32'(b_to), 32'd0);
        check("tie_iter_b", 32'(b_iter), 32'd1);

        run(6, 200);
        check("cap_iter_b", 32'(b_iter), 32'd3);
        check("cap_timeout_err_b", 32'(b_to), 32'd0);
        check("cap_done_b", done_b, 1);
        check("cap_iter_a", 32'(a_iter), 32'd4);

        run(7, 200);
        check("start_in_read_dp_reset", dpr_a, 1);
        check("start_in_read_iter", 32'(a_iter), 32'd1);
        check("start_in_read_done", done_a, 1);

        // reset while in C3
        clr();
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (ma.phase != 4 && n < 40) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            n++;
        end
        check("reach_c3", 32'(a_state), 32'd4);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_abort_a", 32'(last_a), 32'd0);
        check("reset_abort_b", 32'(last_b), 32'd0);
        check("reset_no_done", done_a + done_b, 0);

        // random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/diffeq_sequencer.md
Name: diffeq_sequencer

Overview:
Control FSM for the differential-equation datapath. It accepts a start request, streams the four 4-bit operands (x, dx, a, u) into the datapath through the shared `in` bus, and steps the datapath through COMPUTE_1..COMPUTE_4 once per loop iteration. It ends the run on the datapath's loop-exit flag, an iteration cap or a per-state watchdog timeout, then reports completion. It sits between the top-level host/testbench and the datapath, driving the datapath's `state`, `load_*` and `reset` inputs.

Parameters:
MAX_ITER, 255, maximum loop iterations before a forced stop; must be >= 1.
ITER_W, 8, width of the iteration counter; must hold MAX_ITER.
TIMEOUT, 16, maximum cycles allowed in one compute state while waiting for compute_done.
TO_W, 5, width of the watchdog counter; must hold TIMEOUT.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  run request; sampled only in IDLE
in_valid  input  1  operand nibble on the datapath `in` bus is valid
in_ready  output  1  sequencer will accept the current nibble
compute_done  input  1  datapath completion flag for the current compute state
continue_while  input  1  datapath loop condition (x < a), valid in COMPUTE_4
state  output  3  state code driven to the datapath
load_x  output  1  load pulse for x, to the datapath
load_dx  output  1  load pulse for dx, to the datapath
load_a  output  1  load pulse for a, to the datapath
load_u  output  1  load pulse for u, to the datapath
dp_reset  output  1  one-cycle clear pulse to the datapath's reset input
busy  output  1  high from start acceptance through DONE
done  output  1  one-cycle completion pulse
timeout_err  output  1  sticky flag: last run ended by watchdog expiry
iter_count  output  ITER_W  completed iterations of the last or current run

Behaviour:
- State codes (must match the datapath): IDLE=000, READ=001, C1=010, C2=011, C3=100, C4=101, DONE=110; 111 is never driven.
- Reset (synchronous, on clk edge):
  - state=IDLE.
  - All outputs 0, including iter_count and timeout_err.
  - Internal counters 0.
  - Asserting reset mid-run aborts the run on that edge; no done pulse is issued.
- IDLE:
  - On start=1, go to READ and clear iter_count and timeout_err.
  - start in any other state is ignored.
- READ, first cycle:
  - dp_reset=1 and in_ready=0.
  - Nibble index is cleared to 0.
- READ, following cycles:
  - in_ready=1.
  - Operand order by nibble index: 0=x, 1=dx, 2=a, 3=u.
  - A nibble is accepted when in_valid && in_ready.
  - The matching load_* is asserted combinationally in the same cycle, so the datapath captures `in` on that edge.
  - At most one load_* is high at any time.
  - in_valid low: hold, with no load asserted.
  - After u is accepted, go to C1.
  - Minimum READ duration is 5 cycles.
- Compute states C1..C4:
  - Cycle 0 of each state is a settle cycle: compute_done is ignored, because the datapath registers it one clock late and may still show the previous state's value.
  - From cycle 1 on, compute_done=1 advances the FSM: C1->C2->C3->C4.
  - Minimum is 2 cycles per state, 8 cycles per iteration.
  - The watchdog counter resets on every state entry and increments each compute cycle.
  - If it reaches TIMEOUT without compute_done, set timeout_err=1 and go to DONE.
- C4 exit (compute_done=1, after the settle cycle):
  - iter_count increments, saturating at MAX_ITER.
  - If continue_while=1 and the new iter_count < MAX_ITER, go to C1.
  - Otherwise go to DONE.
- DONE:
  - Lasts 1 cycle with done=1, then goes to IDLE.
  - iter_count and timeout_err hold until the next accepted start.
- busy=1 in every state except IDLE.
- Simultaneous compute_done and watchdog expiry in the same cycle: compute_done wins, and no error is raised.

Decomposition:
- Package diffeq_pkg holds the 3-bit state codes shared with the datapath and the operand-index constants (0..3).
- One natural sub-module: cycle_watchdog.
  - Inputs: clear, enable.
  - Output: expired.
  - Parameters: TIMEOUT, TO_W.
  - Reused by other compute-unit controllers.

Test Plan:
1. Basic single-iteration run.
   - Stimulus: reset; start; stream x=0, dx=1, a=1, u=2 with in_valid held high; bench datapath model raises compute_done on cycle 1 of each state; continue_while=0 at C4.
   - Expected: exactly one each of load_x, load_dx, load_a, load_u in that order; dp_reset in the first READ cycle; state sequence 001x5, 010,010, 011,011, 100,100, 101,101, 110; done pulses once; iter_count=1.
2. Multi-iteration loop.
   - Stimulus: continue_while=1 for the first 3 C4 exits, then 0.
   - Expected: C1..C4 repeats 4 times; iter_count=4; done issued once.
3. Operand stalls and stale compute_done.
   - Stimulus: in_valid toggles 1,0,0,1,0,1,1; hold compute_done=1 continuously.
   - Expected: loads occur only on valid cycles; each compute state still dwells exactly 2 cycles (settle cycle honoured).
4. Watchdog expiry.
   - Stimulus: TIMEOUT=4; compute_done never asserted in C2.
   - Expected: after 4 cycles in C2, move to DONE; timeout_err=1; done=1; iter_count=0.
5. Iteration cap.
   - Stimulus: MAX_ITER=3; continue_while held at 1.
   - Expected: stops after the third C4 exit; iter_count=3; timeout_err=0.
6. Reset mid-run and start outside IDLE.
   - Stimulus: assert reset during C3; separately, pulse start during READ.
   - Expected: reset returns state=000 with all outputs 0 on the next edge and no done pulse; start during READ has no effect, with no restart and no extra dp_reset.
